mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shared-memory scheduler for the multi-core build: arbitrates instruction-fetch and data-cache miss traffic from both cores onto the single RAM port.
- Latches one winning request, sequences it through the RAM handshake and returns a one-cycle completion strobe with load data to the winner.
- Sits between the per-core cache/datapath request ports and the RAM controller.

Parameters:
NREQ, 4, number of requesters. Index order: 0 = core0 I, 1 = core0 D, 2 = core1 I, 3 = core1 D. Odd index = data requester.
AW, 32, address width.
DW, 32, data width.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
req_ren  input  NREQ  read request per requester
req_wen  input  NREQ  write request per requester
req_addr  input  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
req_store  input  NREQ*DW  flattened write data; same indexing
req_done  output  NREQ  one-cycle completion strobe per requester
req_load  output  DW  read data, valid while the winner's req_done is high
ram_ren  output  1  RAM read enable
ram_wen  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_store  output  DW  RAM write data
ram_load  input  DW  RAM read data
ram_ready  input  1  RAM access complete this cycle
busy  output  1  high in every state except IDLE
grant_id  output  $clog2(NREQ)  index of the latched winner

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset, sampled on a CLK edge with RST=1:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - Latched addr, data and op cleared.
  - All outputs 0.
- A requester is active when req_ren[i] | req_wen[i].
- If both ren and wen are high, the request is a write.
- IDLE:
  - If any requester is active, pick the first active index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch its index, addr, store data and op. Go to ACCESS next cycle.
  - With no request, stay in IDLE.
  - RAM outputs are 0 in IDLE.
- ACCESS:
  - Drive ram_addr/ram_store from the latched values.
  - Assert ram_ren or ram_wen (never both).
  - Hold all of these stable until ram_ready=1 is sampled.
  - On ram_ready=1: register ram_load into req_load (writes register 0) and go to RESP.
  - No timeout; wait states are unbounded.
- RESP:
  - req_done[grant_id]=1 for exactly this cycle; all other done bits are 0.
  - RAM enables are 0.
  - rr_ptr <= (grant_id+1) mod NREQ.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0; RAM enable from cycle 1.
  - With ram_ready at cycle 1, done is at cycle 2.
  - Next arbitration is at cycle 3.
  - Minimum turnaround is 3 cycles per transaction.
- Requester contract:
  - Hold ren/wen/addr/store until done.
  - Deassert in the done cycle or the next one. A request still high in IDLE after done is treated as a new request.
- The latched request is immune to input changes. A dropped request mid-ACCESS still completes and still pulses done.
- RST asserted mid-ACCESS:
  - Abandons the transaction; RAM enables are 0 the next cycle.
  - No done is issued; rr_ptr returns to 0.
- Simultaneous requests: at most one grant per transaction. Each requester waits at most NREQ-1 other transactions (no starvation).
- req_load is undefined for write transactions except that it reads as 0.

Optional Feature:
- Macro: MEM_ARB_DATA_PRIORITY_EN.
- Defined:
  - In IDLE, if any odd-index (data) requester is active, only data requesters compete, in round-robin order from rr_ptr.
  - Instruction requesters win only when no data request is active. This lets a load/store miss unblock the pipeline first.
  - rr_ptr update is unchanged.
- Undefined: pure round-robin over all NREQ requesters as above.

Test Plan:
- Single read: req_ren[1]=1, addr=0x0000_0100, RAM returns 0xDEAD_BEEF with ram_ready at cycle 1 -> ram_ren=1, ram_addr=0x100 at cycle 1; req_done[1]=1 and req_load=0xDEAD_BEEF at cycle 2; busy=0 at cycle 3.
- Write with wait states: req_wen[2]=1, addr=0x200, store=0x1234_5678, ram_ready delayed 4 cycles -> ram_wen/addr/store held stable for 4 cycles; req_done[2] one cycle after ram_ready; req_load=0.
- Round-robin fairness: all 4 held active from reset with ram_ready always 1, macro undefined -> grant order 0,1,2,3,0; done spacing 3 cycles.
- Data priority, macro defined: req_ren[0] and req_ren[1] active after reset with rr_ptr=0 -> requester 1 granted first, then 0.
- Reset mid-access: RST pulsed during ACCESS for requester 3 -> next cycle state=IDLE, ram_ren=0, no req_done pulse; a request from 3 re-raised after reset is granted normally.
- Ren+wen together on requester 0 -> ram_wen=1, ram_ren=0 for the whole access.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shared RAM port scheduler: round-robin over NREQ requesters (MEM_ARB_DATA_PRIORITY_EN favours odd/data ports).
// Latency: enable 1 cycle after grant, done 1 cycle after ram_ready, 3-cycle minimum turnaround.
// Backpressure: ram_ready stretches ACCESS indefinitely; requesters hold until their done strobe.
module mem_bus_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_ren,
    input  logic [NREQ-1:0]         req_wen,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_store,
    output logic [NREQ-1:0]         req_done,
    output logic [DW-1:0]           req_load,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [AW-1:0]           ram_addr,
    output logic [DW-1:0]           ram_store,
    input  logic [DW-1:0]           ram_load,
    input  logic                    ram_ready,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   store_q, store_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   load_q, load_d;

    logic [NREQ-1:0] active;
    logic [NREQ-1:0] data_mask;
    logic [NREQ-1:0] cand;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   scan_idx;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_store;
    logic            sel_wr;

    assign active = req_ren | req_wen;

    always_comb begin
        data_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            data_mask[i] = ((i % 2) == 1);
        end
    end

`ifdef MEM_ARB_DATA_PRIORITY_EN
    // A pending load/store miss stalls a pipeline, so data ports shut out fetches while any is active.
    assign cand = (|(active & data_mask)) ? (active & data_mask) : active;
`else
    assign cand = active;
`endif

    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && cand[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_store = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_store = req_store[i*DW +: DW];
                sel_wr    = req_wen[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            load_q   <= load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        load_d    = load_q;
        req_done  = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    addr_d  = sel_addr;
                    store_d = sel_store;
                    wr_d    = sel_wr;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_addr  = addr_q;
                ram_store = store_q;
                ram_ren   = ~wr_q;
                ram_wen   = wr_q;
                if (ram_ready) begin
                    load_d  = wr_q ? '0 : ram_load;
                    state_d = RESP;
                end
            end
            RESP: begin
                req_done = NREQ'(1) << grant_q;
                rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_load = load_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; outputs are sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [NREQ-1:0]    req_done;
    logic [DW-1:0]      req_load;
    logic               ram_ren;
    logic               ram_wen;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_store;
    logic [DW-1:0]      ram_load;
    logic               ram_ready;
    logic               busy;
    logic [1:0]         grant_id;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store),
        .req_done(req_done), .req_load(req_load),
        .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_store(ram_store),
        .ram_load(ram_load), .ram_ready(ram_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    logic [1:0] first_exp, second_exp;

    initial begin
        RST       = 1'b1;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_store = '0;
        ram_load  = '0;
        ram_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_busy",  64'(busy),     64'(0));
        check("rst_done",  64'(req_done), 64'(0));
        check("rst_ren",   64'(ram_ren),  64'(0));
        check("rst_wen",   64'(ram_wen),  64'(0));
        check("rst_addr",  64'(ram_addr), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_load",  64'(req_load), 64'(0));

        // Single read on requester 1
        req_ren[1]          = 1'b1;
        req_addr[1*AW +: AW] = 32'h0000_0100;
        ram_load            = 32'hDEAD_BEEF;
        ram_ready           = 1'b1;
        tick();
        check("rd_c1_ren",   64'(ram_ren),  64'(1));
        check("rd_c1_wen",   64'(ram_wen),  64'(0));
        check("rd_c1_addr",  64'(ram_addr), 64'(32'h100));
        check("rd_c1_grant", 64'(grant_id), 64'(1));
        check("rd_c1_done",  64'(req_done), 64'(0));
        tick();
        check("rd_c2_done",  64'(req_done), 64'(4'b0010));
        check("rd_c2_load",  64'(req_load), 64'(32'hDEAD_BEEF));
        check("rd_c2_ren",   64'(ram_ren),  64'(0));
        req_ren = '0;
        tick();
        check("rd_c3_busy",  64'(busy),     64'(0));
        check("rd_c3_done",  64'(req_done), 64'(0));

        // Write on requester 2 with four wait cycles
        ram_ready            = 1'b0;
        ram_load             = 32'hFFFF_0000;
        req_wen[2]           = 1'b1;
        req_addr[2*AW +: AW]  = 32'h0000_0200;
        req_store[2*DW +: DW] = 32'h1234_5678;
        tick();
        for (int w = 0; w < 4; w++) begin
            check("wr_wait_wen",   64'(ram_wen),   64'(1));
            check("wr_wait_ren",   64'(ram_ren),   64'(0));
            check("wr_wait_addr",  64'(ram_addr),  64'(32'h200));
            check("wr_wait_store", 64'(ram_store), 64'(32'h1234_5678));
            check("wr_wait_done",  64'(req_done),  64'(0));
            // Change inputs mid-access: the latched copy must be unaffected
            req_addr[2*AW +: AW] = 32'h0000_0BAD;
            if (w == 3) ram_ready = 1'b1;
            tick();
        end
        check("wr_done",  64'(req_done), 64'(4'b0100));
        check("wr_load",  64'(req_load), 64'(0));
        check("wr_wen_off", 64'(ram_wen), 64'(0));
        req_wen = '0;
        tick();
        check("wr_idle",  64'(busy), 64'(0));

        // ren and wen together on requester 0 is a write
        ram_ready            = 1'b0;
        req_ren[0]           = 1'b1;
        req_wen[0]           = 1'b1;
        req_addr[0*AW +: AW]  = 32'h0000_0040;
        req_store[0*DW +: DW] = 32'hA5A5_5A5A;
        tick();
        for (int w = 0; w < 2; w++) begin
            check("rw_wen", 64'(ram_wen), 64'(1));
            check("rw_ren", 64'(ram_ren), 64'(0));
            if (w == 1) ram_ready = 1'b1;
            tick();
        end
        check("rw_done", 64'(req_done), 64'(4'b0001));
        req_ren = '0;
        req_wen = '0;
        tick();

        // Round-robin fairness from reset, all four held active
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = 32'h1000 + 32'(i);
        req_ren   = 4'b1111;
        ram_ready = 1'b1;
        do_reset();
        check("rr_rst_busy", 64'(busy), 64'(0));
        for (int t = 0; t < 5; t++) begin
            tick();
            check("rr_grant",   64'(grant_id), 64'(t % NREQ));
            check("rr_addr",    64'(ram_addr), 64'(32'h1000 + 32'(t % NREQ)));
            check("rr_acc_done", 64'(req_done), 64'(0));
            tick();
            check("rr_done",    64'(req_done), 64'(4'b0001 << (t % NREQ)));
            tick();
            check("rr_idle",    64'(busy), 64'(0));
        end
        req_ren = '0;

        // Data priority vs plain round-robin: requesters 0 and 1 after reset
`ifdef MEM_ARB_DATA_PRIORITY_EN
        first_exp  = 2'd1;
        second_exp = 2'd0;
`else
        first_exp  = 2'd0;
        second_exp = 2'd1;
`endif
        do_reset();
        req_ren = 4'b0011;
        tick();
        check("pri_first", 64'(grant_id), 64'(first_exp));
        tick();
        check("pri_first_done", 64'(req_done), 64'(4'b0001 << first_exp));
        req_ren[first_exp] = 1'b0;
        tick();
        tick();
        check("pri_second", 64'(grant_id), 64'(second_exp));
        tick();
        check("pri_second_done", 64'(req_done), 64'(4'b0001 << second_exp));
        req_ren = '0;
        tick();

        // Reset in the middle of an access from requester 3
        do_reset();
        ram_ready            = 1'b0;
        req_ren[3]           = 1'b1;
        req_addr[3*AW +: AW]  = 32'h0000_0300;
        tick();
        check("mid_grant", 64'(grant_id), 64'(3));
        check("mid_ren",   64'(ram_ren),  64'(1));
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_busy",  64'(busy),     64'(0));
        check("mid_rst_ren",   64'(ram_ren),  64'(0));
        check("mid_rst_done",  64'(req_done), 64'(0));
        check("mid_rst_grant", 64'(grant_id), 64'(0));
        ram_ready = 1'b1;
        tick();
        check("mid_regrant",  64'(grant_id), 64'(3));
        check("mid_reren",    64'(ram_ren),  64'(1));
        check("mid_readdr",   64'(ram_addr), 64'(32'h300));
        tick();
        check("mid_redone",   64'(req_done), 64'(4'b1000));
        req_ren = '0;
        tick();
        check("mid_end_idle", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
